// File: rtl/router_fsm_nport.sv
// router_fsm_nport
// Packet sequencing controller for an N-output router. It moves one packet
// at a time from the input register block into the output FIFO addressed by
// the header byte. The destination is latched at header time, so the wait
// and soft-reset decisions only look at the addressed FIFO.
//
// Packets are discarded when the header addresses a port that does not
// exist, or when the addressed FIFO stays non-empty for WAIT_TIMEOUT cycles
// (WAIT_TIMEOUT = 0 waits forever). Each discarded packet bumps a
// saturating drop counter.
//
// state              | meaning
// -------------------+----------------------------------------------------
// S_DECODE           | idle, waiting for a header byte (pkt_valid)
// S_LFD              | load first data (header) into the selected FIFO
// S_WAIT             | selected FIFO still draining, bounded by a timer
// S_LD               | streaming payload bytes into the selected FIFO
// S_FFS              | selected FIFO full, holding the source off
// S_LAF              | one load cycle after the FIFO frees up
// S_LP               | loading the parity byte
// S_CPE              | parity check, internal register reset
// S_DROP             | discarding the rest of the current packet
//
// Ports
//   i_clk, i_resetn          clock (rising edge), synchronous active-low reset
//   i_pkt_valid              source byte valid
//   i_data_in                header address field
//   i_parity_done            parity byte captured by the register block
//   i_low_pkt_valid          pkt_valid fell while the FIFO was full
//   i_fifo_full              full flag of the selected FIFO (muxed outside)
//   i_fifo_empty             per-FIFO empty flags
//   i_soft_reset             per-FIFO soft-reset pulses
//   o_dest_sel               one-hot latched destination
//   o_detect_add .. o_drop_state   registered state decodes
//   o_write_enb_reg          write enable for the selected FIFO
//   o_busy                   back-pressure to the source
//   o_wait_timeout           one-cycle pulse on a timeout-driven drop
//   o_drop_count             saturating count of dropped packets

module router_fsm_nport #(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 1023,
    parameter int DROP_CNT_W   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_pkt_valid,
    input  logic [ADDR_W-1:0]     i_data_in,
    input  logic                  i_parity_done,
    input  logic                  i_low_pkt_valid,
    input  logic                  i_fifo_full,
    input  logic [NUM_PORTS-1:0]  i_fifo_empty,
    input  logic [NUM_PORTS-1:0]  i_soft_reset,
    output logic [NUM_PORTS-1:0]  o_dest_sel,
    output logic                  o_detect_add,
    output logic                  o_lfd_state,
    output logic                  o_ld_state,
    output logic                  o_laf_state,
    output logic                  o_full_state,
    output logic                  o_rst_int_reg,
    output logic                  o_write_enb_reg,
    output logic                  o_busy,
    output logic                  o_drop_state,
    output logic                  o_wait_timeout,
    output logic [DROP_CNT_W-1:0] o_drop_count
);

    localparam int TMR_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST =
        (WAIT_TIMEOUT > 0) ? TMR_W'(WAIT_TIMEOUT - 1) : '0;
    localparam logic [ADDR_W:0] PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);

    typedef enum logic [3:0] {
        S_DECODE = 4'd0,
        S_LFD    = 4'd1,
        S_WAIT   = 4'd2,
        S_LD     = 4'd3,
        S_FFS    = 4'd4,
        S_LAF    = 4'd5,
        S_LP     = 4'd6,
        S_CPE    = 4'd7,
        S_DROP   = 4'd8
    } state_t;

    state_t                  r_state;
    logic [NUM_PORTS-1:0]    r_dest_sel;
    logic [TMR_W-1:0]        r_timer;
    logic [DROP_CNT_W-1:0]   r_drop_count;
    logic                    r_wait_timeout;
    logic                    r_detect_add;
    logic                    r_lfd_state;
    logic                    r_ld_state;
    logic                    r_laf_state;
    logic                    r_full_state;
    logic                    r_rst_int_reg;
    logic                    r_write_enb_reg;
    logic                    r_busy;
    logic                    r_drop_state;

    state_t                  w_next;
    logic                    w_addr_bad;
    logic [NUM_PORTS-1:0]    w_hdr_onehot;
    logic                    w_hdr_empty;
    logic                    w_dest_empty;
    logic                    w_dest_abort;
    logic                    w_timeout_hit;

    // Header decode uses the live address; everything after the header uses
    // the latched one-hot destination.
    assign w_addr_bad    = ({1'b0, i_data_in} >= PORT_LIMIT);
    assign w_hdr_onehot  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << i_data_in;
    assign w_hdr_empty   = |(i_fifo_empty & w_hdr_onehot);
    assign w_dest_empty  = |(i_fifo_empty & r_dest_sel);
    assign w_dest_abort  = |(i_soft_reset & r_dest_sel);
    assign w_timeout_hit = (WAIT_TIMEOUT != 0) && (r_timer == TMR_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_DECODE: begin
                if (i_pkt_valid) begin
                    if (w_addr_bad)       w_next = S_DROP;
                    else if (w_hdr_empty) w_next = S_LFD;
                    else                  w_next = S_WAIT;
                end
            end
            S_LFD:  w_next = S_LD;
            S_WAIT: begin
                // Empty wins over a coincident timeout.
                if (w_dest_empty)       w_next = S_LFD;
                else if (w_timeout_hit) w_next = S_DROP;
            end
            S_LD: begin
                if (i_fifo_full)       w_next = S_FFS;
                else if (!i_pkt_valid) w_next = S_LP;
            end
            S_LP:   w_next = S_CPE;
            S_CPE:  w_next = i_fifo_full ? S_FFS : S_DECODE;
            S_FFS:  w_next = i_fifo_full ? S_FFS : S_LAF;
            S_LAF: begin
                if (i_parity_done)        w_next = S_DECODE;
                else if (i_low_pkt_valid) w_next = S_LP;
                else                      w_next = S_LD;
            end
            S_DROP: w_next = i_pkt_valid ? S_DROP : S_DECODE;
            default: w_next = S_DECODE;
        endcase

        // A read-side timeout on the selected FIFO aborts the packet from
        // any active state; idle and discard states have nothing to abort.
        if (w_dest_abort && (r_state != S_DECODE) && (r_state != S_DROP))
            w_next = S_DECODE;
    end

    // Outputs are registered from the next state so they present as Moore
    // decodes of the current state without a combinational path.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state         <= S_DECODE;
            r_dest_sel      <= '0;
            r_timer         <= '0;
            r_drop_count    <= '0;
            r_wait_timeout  <= 1'b0;
            r_detect_add    <= 1'b1;
            r_lfd_state     <= 1'b0;
            r_ld_state      <= 1'b0;
            r_laf_state     <= 1'b0;
            r_full_state    <= 1'b0;
            r_rst_int_reg   <= 1'b0;
            r_write_enb_reg <= 1'b0;
            r_busy          <= 1'b0;
            r_drop_state    <= 1'b0;
        end else begin
            r_state <= w_next;

            if ((r_state == S_DECODE) && i_pkt_valid && !w_addr_bad)
                r_dest_sel <= w_hdr_onehot;

            // Timer is zero on every entry to the wait state.
            if (r_state == S_WAIT)
                r_timer <= r_timer + TMR_W'(1);
            else
                r_timer <= '0;

            r_wait_timeout <= (r_state == S_WAIT) && (w_next == S_DROP);

            if ((w_next == S_DROP) && (r_state != S_DROP) && (r_drop_count != '1))
                r_drop_count <= r_drop_count + DROP_CNT_W'(1);

            r_detect_add    <= (w_next == S_DECODE);
            r_lfd_state     <= (w_next == S_LFD);
            r_ld_state      <= (w_next == S_LD);
            r_laf_state     <= (w_next == S_LAF);
            r_full_state    <= (w_next == S_FFS);
            r_rst_int_reg   <= (w_next == S_CPE);
            r_drop_state    <= (w_next == S_DROP);
            r_write_enb_reg <= (w_next == S_LD) || (w_next == S_LP) || (w_next == S_LAF);
            r_busy          <= !((w_next == S_DECODE) || (w_next == S_LD) || (w_next == S_DROP));
        end
    end

    assign o_dest_sel      = r_dest_sel;
    assign o_detect_add    = r_detect_add;
    assign o_lfd_state     = r_lfd_state;
    assign o_ld_state      = r_ld_state;
    assign o_laf_state     = r_laf_state;
    assign o_full_state    = r_full_state;
    assign o_rst_int_reg   = r_rst_int_reg;
    assign o_write_enb_reg = r_write_enb_reg;
    assign o_busy          = r_busy;
    assign o_drop_state    = r_drop_state;
    assign o_wait_timeout  = r_wait_timeout;
    assign o_drop_count    = r_drop_count;

endmodule
